// File: rtl/mmu_inst_utlb.sv
// Instruction MMU: kseg0/1 direct map, other segments via a fully-associative uTLB refilled from the JTLB.
// Latency: hits and unmapped fetches translate combinationally; a uTLB miss costs JTLB latency + 1 cycle.
// Backpressure: stallreq holds fetch during refill or flush-drop; jtlb_req is held until jtlb_ack. Option: UTLB_PERF_CNT_EN adds miss/stall counters.
module mmu_inst_utlb #(
    parameter int ENTRIES = 4,
    parameter int ASID_W  = 8,
    parameter int PFN_W   = 20
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_en,
    input  logic [31:0]       i_vaddr,
    input  logic [ASID_W-1:0] asid,
    output logic [31:0]       i_rdata,
    output logic              ibus_en,
    output logic [31:0]       ibus_paddr,
    output logic              ibus_cached,
    input  logic [31:0]       ibus_rdata,
    output logic              stallreq,
    output logic              exc_refill,
    output logic              exc_invalid,
    input  logic              utlb_flush,
    output logic              jtlb_req,
    output logic [19:0]       jtlb_vpn,
    output logic [ASID_W-1:0] jtlb_asid,
    input  logic              jtlb_ack,
    input  logic              jtlb_hit,
    input  logic [PFN_W-1:0]  jtlb_pfn,
    input  logic [2:0]        jtlb_c,
    input  logic              jtlb_v,
    input  logic              jtlb_g
`ifdef UTLB_PERF_CNT_EN
    ,
    output logic [31:0]       utlb_miss_cnt,
    output logic [31:0]       utlb_stall_cnt
`endif
);

    localparam int IW = $clog2(ENTRIES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]        state;
    logic [IW-1:0]     rr_ptr;

    // uTLB storage; only the valid bits need a reset value
    logic [ENTRIES-1:0] ent_valid;
    logic [19:0]        ent_vpn  [ENTRIES];
    logic [ASID_W-1:0]  ent_asid [ENTRIES];
    logic               ent_g    [ENTRIES];
    logic [PFN_W-1:0]   ent_pfn  [ENTRIES];
    logic [2:0]         ent_c    [ENTRIES];
    logic               ent_v    [ENTRIES];

    logic               fault_valid;
    logic [19:0]        fault_vpn;
    logic [ASID_W-1:0]  fault_asid;

    logic [19:0]        vpn;
    logic               mapped;
    logic               hit;
    logic [PFN_W-1:0]   hit_pfn;
    logic [2:0]         hit_c;
    logic               hit_v;
    logic               fault_match;
    logic               lookup_miss;
    logic               go_req;
    logic               fill;
    logic               fault_set;

    assign vpn    = i_vaddr[31:12];
    // 0x8..0xB in the top nibble is exactly vaddr[31:30] == 2'b10
    assign mapped = (i_vaddr[31:30] != 2'b10);

    // Fully-associative lookup; the first matching entry wins (a second match would be a fill bug)
    always_comb begin
        hit     = 1'b0;
        hit_pfn = '0;
        hit_c   = '0;
        hit_v   = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!hit && ent_valid[i] && (ent_vpn[i] == vpn) && (ent_g[i] || (ent_asid[i] == asid))) begin
                hit     = 1'b1;
                hit_pfn = ent_pfn[i];
                hit_c   = ent_c[i];
                hit_v   = ent_v[i];
            end
        end
    end

    assign fault_match = fault_valid && (fault_vpn == vpn) && (fault_asid == asid);
    assign lookup_miss = i_en && mapped && !hit && !fault_match;

    // A miss seen together with a flush is postponed one cycle so it looks up the flushed uTLB
    assign go_req    = (state == S_IDLE) && lookup_miss && !utlb_flush;
    assign fill      = (state == S_REQ) && jtlb_ack && jtlb_hit && !utlb_flush;
    assign fault_set = (state == S_REQ) && jtlb_ack && !jtlb_hit && !utlb_flush;

    assign exc_refill  = i_en && mapped && !hit && fault_match;
    assign exc_invalid = i_en && mapped && hit && !hit_v;
    assign stallreq    = (state != S_IDLE) || lookup_miss;
    assign jtlb_req    = (state == S_REQ);

    assign ibus_en = i_en && !stallreq && !exc_refill && !exc_invalid;
    assign i_rdata = ibus_en ? ibus_rdata : 32'd0;

    // Address and cacheability: segment map for kseg0/1, uTLB entry otherwise
    always_comb begin
        if (mapped) begin
            ibus_paddr  = 32'({hit_pfn, i_vaddr[11:0]});
            ibus_cached = (hit_c != 3'd2);
        end else begin
            ibus_paddr  = {3'b000, i_vaddr[28:0]};
            ibus_cached = !i_vaddr[29];
        end
    end

    // Refill FSM: IDLE -> REQ on miss; a flush in REQ without ack goes to DROP to swallow the stale ack
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            jtlb_vpn  <= '0;
            jtlb_asid <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go_req) begin
                        state     <= S_REQ;
                        jtlb_vpn  <= vpn;
                        jtlb_asid <= asid;
                    end
                end
                S_REQ: begin
                    if (jtlb_ack)        state <= S_IDLE;
                    else if (utlb_flush) state <= S_DROP;
                end
                S_DROP: begin
                    if (jtlb_ack) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Valid bits and round-robin victim pointer; flush clears validity but keeps the pointer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ent_valid <= '0;
            rr_ptr    <= '0;
        end else if (utlb_flush) begin
            ent_valid <= '0;
        end else if (fill) begin
            ent_valid[rr_ptr] <= 1'b1;
            rr_ptr            <= rr_ptr + IW'(1);
        end
    end

    // Entry payload written at the victim slot on a successful refill
    always_ff @(posedge clk) begin
        if (fill) begin
            ent_vpn[rr_ptr]  <= jtlb_vpn;
            ent_asid[rr_ptr] <= jtlb_asid;
            ent_g[rr_ptr]    <= jtlb_g;
            ent_pfn[rr_ptr]  <= jtlb_pfn;
            ent_c[rr_ptr]    <= jtlb_c;
            ent_v[rr_ptr]    <= jtlb_v;
        end
    end

    // Remembered JTLB miss so a held fetch raises a refill exception instead of re-requesting forever
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fault_valid <= 1'b0;
            fault_vpn   <= '0;
            fault_asid  <= '0;
        end else if (utlb_flush) begin
            fault_valid <= 1'b0;
        end else if (fault_set) begin
            fault_valid <= 1'b1;
            fault_vpn   <= jtlb_vpn;
            fault_asid  <= jtlb_asid;
        end else if (i_en && mapped && !fault_match) begin
            fault_valid <= 1'b0;
        end
    end

`ifdef UTLB_PERF_CNT_EN
    // Saturating miss and stall-cycle counters
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            utlb_miss_cnt  <= 32'd0;
            utlb_stall_cnt <= 32'd0;
        end else begin
            if (go_req && (utlb_miss_cnt != 32'hFFFF_FFFF))
                utlb_miss_cnt <= utlb_miss_cnt + 32'd1;
            if (stallreq && (utlb_stall_cnt != 32'hFFFF_FFFF))
                utlb_stall_cnt <= utlb_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mmu_inst_utlb.sv
// Bench for mmu_inst_utlb: scoreboard of expected fetch results, simple JTLB responder.
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: fetches are held until the DUT completes or flags an exception, bounded per fetch.
module tb_mmu_inst_utlb;
    localparam int ENTRIES = 4;
    localparam int ASID_W  = 8;
    localparam int PFN_W   = 20;
    localparam logic [31:0] RD_XOR = 32'hA5C3_0F96;

    logic              clk = 1'b0;
    logic              resetn;
    logic              i_en;
    logic [31:0]       i_vaddr;
    logic [ASID_W-1:0] asid;
    logic [31:0]       i_rdata;
    logic              ibus_en;
    logic [31:0]       ibus_paddr;
    logic              ibus_cached;
    logic [31:0]       ibus_rdata;
    logic              stallreq;
    logic              exc_refill;
    logic              exc_invalid;
    logic              utlb_flush;
    logic              jtlb_req;
    logic [19:0]       jtlb_vpn;
    logic [ASID_W-1:0] jtlb_asid;
    logic              jtlb_ack;
    logic              jtlb_hit;
    logic [PFN_W-1:0]  jtlb_pfn;
    logic [2:0]        jtlb_c;
    logic              jtlb_v;
    logic              jtlb_g;

    always #5 clk = ~clk;

    assign ibus_rdata = i_vaddr ^ RD_XOR;

    mmu_inst_utlb #(.ENTRIES(ENTRIES), .ASID_W(ASID_W), .PFN_W(PFN_W)) dut (
        .clk(clk), .resetn(resetn), .i_en(i_en), .i_vaddr(i_vaddr), .asid(asid),
        .i_rdata(i_rdata), .ibus_en(ibus_en), .ibus_paddr(ibus_paddr),
        .ibus_cached(ibus_cached), .ibus_rdata(ibus_rdata), .stallreq(stallreq),
        .exc_refill(exc_refill), .exc_invalid(exc_invalid), .utlb_flush(utlb_flush),
        .jtlb_req(jtlb_req), .jtlb_vpn(jtlb_vpn), .jtlb_asid(jtlb_asid),
        .jtlb_ack(jtlb_ack), .jtlb_hit(jtlb_hit), .jtlb_pfn(jtlb_pfn),
        .jtlb_c(jtlb_c), .jtlb_v(jtlb_v), .jtlb_g(jtlb_g)
    );

    typedef struct {
        logic        en;
        logic [31:0] paddr;
        logic        cached;
        logic        refill;
        logic        invalid;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ack_lat = 1;
    bit   auto_resp = 1'b1;
    int   wcnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t e_ok(input logic [31:0] pa, input logic c, input logic [31:0] va);
        exp_t e;
        e.en = 1'b1; e.paddr = pa; e.cached = c; e.refill = 1'b0; e.invalid = 1'b0;
        e.rdata = va ^ RD_XOR;
        return e;
    endfunction

    function automatic exp_t e_exc(input logic rf, input logic inv);
        exp_t e;
        e.en = 1'b0; e.paddr = 32'd0; e.cached = 1'b0; e.refill = rf; e.invalid = inv;
        e.rdata = 32'd0;
        return e;
    endfunction

    task automatic set_jt(input logic h, input logic [PFN_W-1:0] p, input logic [2:0] c,
                          input logic v, input logic g);
        jtlb_hit = h; jtlb_pfn = p; jtlb_c = c; jtlb_v = v; jtlb_g = g;
    endtask

    // One clock: advance to just after posedge and run the JTLB responder
    task automatic tick();
        @(posedge clk);
        #1;
        jtlb_ack = 1'b0;
        if (auto_resp && jtlb_req) begin
            if (wcnt >= ack_lat - 1) begin
                jtlb_ack = 1'b1;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    endtask

    // Pop the oldest expectation and compare against the DUT outputs of this cycle
    task automatic observe(input string tag);
        exp_t e;
        chk({tag, ":sb"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk({tag, ":en"},      64'(ibus_en),     64'(e.en));
        chk({tag, ":refill"},  64'(exc_refill),  64'(e.refill));
        chk({tag, ":invalid"}, 64'(exc_invalid), 64'(e.invalid));
        chk({tag, ":rdata"},   64'(i_rdata),     64'(e.rdata));
        if (e.en) begin
            chk({tag, ":paddr"},  64'(ibus_paddr),  64'(e.paddr));
            chk({tag, ":cached"}, 64'(ibus_cached), 64'(e.cached));
        end
    endtask

    // Drive a fetch, hold it until it completes or faults, then check result and stall count
    task automatic fetch(input string tag, input logic [31:0] va, input logic [7:0] as,
                         input exp_t e, input int exp_stall);
        int n;
        n = 0;
        sb.push_back(e);
        i_en = 1'b1; i_vaddr = va; asid = as;
        forever begin
            @(negedge clk);
            if (ibus_en || exc_refill || exc_invalid) break;
            n++;
            if (n > 50) break;
            tick();
        end
        observe(tag);
        chk({tag, ":stall"}, 64'(n), 64'(exp_stall));
        tick();
    endtask

    initial begin
        resetn = 1'b0; i_en = 1'b0; i_vaddr = 32'd0; asid = '0; utlb_flush = 1'b0;
        jtlb_ack = 1'b0;
        set_jt(1'b0, '0, 3'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst:jtlb_req", 64'(jtlb_req),    64'd0);
        chk("rst:stallreq", 64'(stallreq),    64'd0);
        chk("rst:refill",   64'(exc_refill),  64'd0);
        chk("rst:invalid",  64'(exc_invalid), 64'd0);
        chk("rst:ibus_en",  64'(ibus_en),     64'd0);
        tick();
        resetn = 1'b1;
        tick();

        // unmapped segments
        fetch("kseg0", 32'h9FC0_0000, 8'd0, e_ok(32'h1FC0_0000, 1'b1, 32'h9FC0_0000), 0);
        fetch("kseg1", 32'hBFC0_0010, 8'd0, e_ok(32'h1FC0_0010, 1'b0, 32'hBFC0_0010), 0);

        // first refill, ack two cycles after the miss
        ack_lat = 2;
        set_jt(1'b1, 20'h12345, 3'd3, 1'b1, 1'b0);
        fetch("miss1", 32'h0040_0000, 8'd5, e_ok(32'h1234_5000, 1'b1, 32'h0040_0000), 3);
        fetch("hit1",  32'h0040_0004, 8'd5, e_ok(32'h1234_5004, 1'b1, 32'h0040_0004), 0);

        // same page, other ASID: non-global entry misses; minimum penalty
        ack_lat = 1;
        set_jt(1'b1, 20'h22222, 3'd2, 1'b1, 1'b0);
        fetch("asid6", 32'h0040_0000, 8'd6, e_ok(32'h2222_2000, 1'b0, 32'h0040_0000), 2);

        // JTLB miss -> refill exception while held
        set_jt(1'b0, 20'h0, 3'd0, 1'b0, 1'b0);
        fetch("fault", 32'h0080_0000, 8'd6, e_exc(1'b1, 1'b0), 2);
        @(negedge clk);
        chk("fault_hold:refill",  64'(exc_refill), 64'd1);
        chk("fault_hold:stall",   64'(stallreq),   64'd0);
        chk("fault_hold:ibus_en", 64'(ibus_en),    64'd0);
        chk("fault_hold:req",     64'(jtlb_req),   64'd0);
        tick();
        fetch("fault_clr", 32'h0040_0010, 8'd6, e_ok(32'h2222_2010, 1'b0, 32'h0040_0010), 0);
        fetch("fault2", 32'h0080_0000, 8'd6, e_exc(1'b1, 1'b0), 2);

        // page valid bit clear -> invalid exception
        set_jt(1'b1, 20'h33333, 3'd3, 1'b0, 1'b0);
        fetch("inv",     32'h00C0_0000, 8'd6, e_exc(1'b0, 1'b1), 2);
        fetch("inv_hit", 32'h00C0_0010, 8'd6, e_exc(1'b0, 1'b1), 0);

        // global page matches any ASID
        set_jt(1'b1, 20'h44444, 3'd0, 1'b1, 1'b1);
        fetch("glob",     32'h0100_0000, 8'd6, e_ok(32'h4444_4000, 1'b1, 32'h0100_0000), 2);
        fetch("glob_a9",  32'h0100_0ABC, 8'd9, e_ok(32'h4444_4ABC, 1'b1, 32'h0100_0ABC), 0);

        // fifth page replaces entry 0
        set_jt(1'b1, 20'h66666, 3'd3, 1'b1, 1'b0);
        fetch("fill5",    32'h0140_0000, 8'd5, e_ok(32'h6666_6000, 1'b1, 32'h0140_0000), 2);
        fetch("ent1_hit", 32'h0040_0008, 8'd6, e_ok(32'h2222_2008, 1'b0, 32'h0040_0008), 0);
        set_jt(1'b1, 20'h12345, 3'd3, 1'b1, 1'b0);
        fetch("evicted",  32'h0040_0000, 8'd5, e_ok(32'h1234_5000, 1'b1, 32'h0040_0000), 2);

        // flush in REQ, ack next cycle is dropped, then a fresh request
        auto_resp = 1'b0;
        set_jt(1'b1, 20'h77777, 3'd3, 1'b1, 1'b0);
        sb.push_back(e_ok(32'h7777_7000, 1'b1, 32'h0200_0000));
        i_en = 1'b1; i_vaddr = 32'h0200_0000; asid = 8'd5;
        @(negedge clk);
        chk("fl:miss_stall", 64'(stallreq), 64'd1);
        tick();
        utlb_flush = 1'b1;
        @(negedge clk);
        chk("fl:req",     64'(jtlb_req), 64'd1);
        chk("fl:req_vpn", 64'(jtlb_vpn), 64'h02000);
        tick();
        utlb_flush = 1'b0;
        jtlb_ack = 1'b1;
        @(negedge clk);
        chk("fl:drop_req",   64'(jtlb_req), 64'd0);
        chk("fl:drop_stall", 64'(stallreq), 64'd1);
        tick();
        @(negedge clk);
        chk("fl:remiss", 64'(stallreq), 64'd1);
        tick();
        @(negedge clk);
        chk("fl:new_req", 64'(jtlb_req), 64'd1);
        jtlb_ack = 1'b1;
        tick();
        @(negedge clk);
        observe("fl:done");
        tick();

        // flush coincident with ack: no fill
        set_jt(1'b1, 20'h55555, 3'd3, 1'b1, 1'b0);
        sb.push_back(e_ok(32'h5555_5000, 1'b1, 32'h0240_0000));
        i_vaddr = 32'h0240_0000;
        tick();
        utlb_flush = 1'b1;
        jtlb_ack = 1'b1;
        tick();
        utlb_flush = 1'b0;
        @(negedge clk);
        chk("flack:nofill", 64'(stallreq), 64'd1);
        chk("flack:req",    64'(jtlb_req), 64'd0);
        tick();
        @(negedge clk);
        chk("flack:new_req", 64'(jtlb_req), 64'd1);
        jtlb_ack = 1'b1;
        tick();
        @(negedge clk);
        observe("flack:done");
        tick();

        // the global entry was flushed
        auto_resp = 1'b1;
        set_jt(1'b1, 20'h44444, 3'd0, 1'b1, 1'b1);
        fetch("glob_flushed", 32'h0100_0000, 8'd6, e_ok(32'h4444_4000, 1'b1, 32'h0100_0000), 2);

        // flush in IDLE with a simultaneous miss: the request starts a cycle later
        auto_resp = 1'b0;
        set_jt(1'b1, 20'h28280, 3'd3, 1'b1, 1'b0);
        sb.push_back(e_ok(32'h2828_0000, 1'b1, 32'h0280_0000));
        i_vaddr = 32'h0280_0000; asid = 8'd5; utlb_flush = 1'b1;
        tick();
        utlb_flush = 1'b0;
        @(negedge clk);
        chk("flidle:req0", 64'(jtlb_req), 64'd0);
        chk("flidle:stall", 64'(stallreq), 64'd1);
        tick();
        @(negedge clk);
        chk("flidle:req1", 64'(jtlb_req), 64'd1);
        jtlb_ack = 1'b1;
        tick();
        @(negedge clk);
        observe("flidle:done");
        tick();

        // fetch withdrawn during REQ still completes the refill
        set_jt(1'b1, 20'h2C2C2, 3'd3, 1'b1, 1'b0);
        i_vaddr = 32'h02C0_0000;
        tick();
        i_en = 1'b0;
        @(negedge clk);
        chk("noen:req",   64'(jtlb_req), 64'd1);
        chk("noen:stall", 64'(stallreq), 64'd1);
        jtlb_ack = 1'b1;
        tick();
        auto_resp = 1'b1;
        fetch("noen_hit", 32'h02C0_0004, 8'd5, e_ok(32'h2C2C_2004, 1'b1, 32'h02C0_0004), 0);

        // reset in the middle of a refill, late ack ignored
        auto_resp = 1'b0;
        set_jt(1'b1, 20'h30303, 3'd3, 1'b1, 1'b0);
        i_vaddr = 32'h0300_0000;
        tick();
        resetn = 1'b0;
        i_en = 1'b0;
        @(negedge clk);
        chk("rstmid:req",   64'(jtlb_req), 64'd0);
        chk("rstmid:stall", 64'(stallreq), 64'd0);
        tick();
        resetn = 1'b1;
        jtlb_ack = 1'b1;
        @(negedge clk);
        chk("rstmid:late_req", 64'(jtlb_req), 64'd0);
        tick();
        @(negedge clk);
        chk("rstmid:idle_req",   64'(jtlb_req), 64'd0);
        chk("rstmid:idle_stall", 64'(stallreq), 64'd0);
        tick();
        auto_resp = 1'b1;
        fetch("rstmid_miss", 32'h0300_0000, 8'd5, e_ok(32'h3030_3000, 1'b1, 32'h0300_0000), 2);

        i_en = 1'b0;
        chk("sb:drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
